// File: rtl/issue_stage.sv
// issue_stage: read end of the instruction queue. Pops one entry per cycle when
// it is free of RAW/WAW hazards against a 32-entry register scoreboard, expands
// the packed immediate and holds the instruction for the execute units.
//
// Optional feature macro: ISSUE_PERF_EN (issued/stall performance counters).
//
// queue_item_t layout (50 bits, MSB first):
//   [49:44] uopcode    [43:42] exu_type   [41] has_rd  [40] has_rs1  [39] has_rs2
//   [38:34] rd         [33:29] rs1        [28:24] rs2  [23:4] packed_imm
//   [3:2]   imm_type   [1]     taken      [0] shadowed
// exu_type: 0=ALU 1=MUL 2=JMP 3=MEM.  imm_type: 0=I/S 1=B 2=U 3=J.
//
// Handshake: an instruction transfers to execute unit iss_exu_type_o in any
// cycle where iss_valid_o and exu_ready_i[iss_exu_type_o] are both high; while
// iss_valid_o is high and no transfer happens every iss_* field holds still.
// The queue side is a pop strobe: q_pop_o consumes the head in that same cycle.
module issue_stage #(
    parameter int NUM_EXU = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [49:0]        q_item_i,
    input  logic               q_empty_i,
    output logic               q_pop_o,
    input  logic               flush_i,
    input  logic               wb_valid_i,
    input  logic [4:0]         wb_rd_i,
    input  logic [NUM_EXU-1:0] exu_ready_i,
    output logic               iss_valid_o,
    output logic [5:0]         iss_uopcode_o,
    output logic [1:0]         iss_exu_type_o,
    output logic               iss_has_rd_o,
    output logic               iss_has_rs1_o,
    output logic               iss_has_rs2_o,
    output logic [4:0]         iss_rd_o,
    output logic [4:0]         iss_rs1_o,
    output logic [4:0]         iss_rs2_o,
    output logic [31:0]        iss_imm_o,
    output logic               iss_taken_o,
    output logic               iss_shadowed_o,
    output logic [31:0]        sb_o,
    output logic [CNT_W-1:0]   issued_cnt_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_B = 2'd1;
    localparam logic [1:0] IMM_U = 2'd2;

    state_t      state_q, state_d;
    logic [31:0] sb_q, sb_d, sb_eff;
    logic        accept, hazard, held_rd_live;
    logic [31:0] head_imm;

    // Queue head fields
    logic [5:0]  h_uop;
    logic [1:0]  h_exu;
    logic        h_has_rd, h_has_rs1, h_has_rs2;
    logic [4:0]  h_rd, h_rs1, h_rs2;
    logic [19:0] h_pimm;
    logic [1:0]  h_ity;
    logic        h_taken, h_shadowed;

    assign h_uop      = q_item_i[49:44];
    assign h_exu      = q_item_i[43:42];
    assign h_has_rd   = q_item_i[41];
    assign h_has_rs1  = q_item_i[40];
    assign h_has_rs2  = q_item_i[39];
    assign h_rd       = q_item_i[38:34];
    assign h_rs1      = q_item_i[33:29];
    assign h_rs2      = q_item_i[28:24];
    assign h_pimm     = q_item_i[23:4];
    assign h_ity      = q_item_i[3:2];
    assign h_taken    = q_item_i[1];
    assign h_shadowed = q_item_i[0];

    // The output register is the FSM: FULL means an instruction is held.
    assign iss_valid_o = (state_q == S_FULL);
    assign accept      = iss_valid_o & exu_ready_i[iss_exu_type_o];
    assign sb_o        = sb_q;

    // Scoreboard as seen by the head: a writeback this cycle already counts.
    always_comb begin
        sb_eff = sb_q;
        if (wb_valid_i) sb_eff[wb_rd_i] = 1'b0;
    end

    // The held instruction has not reached sb yet, so its rd is checked directly.
    assign held_rd_live = iss_valid_o & iss_has_rd_o & (iss_rd_o != 5'd0);

    // Hazard detection for the queue head
    always_comb begin
        hazard = 1'b0;
        if (h_has_rs1 && h_rs1 != 5'd0 && sb_eff[h_rs1]) hazard = 1'b1;
        if (h_has_rs2 && h_rs2 != 5'd0 && sb_eff[h_rs2]) hazard = 1'b1;
        if (h_has_rd  && h_rd  != 5'd0 && sb_eff[h_rd])  hazard = 1'b1;
        if (held_rd_live && ((h_has_rd  && h_rd  == iss_rd_o) ||
                             (h_has_rs1 && h_rs1 == iss_rd_o) ||
                             (h_has_rs2 && h_rs2 == iss_rd_o)))
            hazard = 1'b1;
    end

    // Pop when the head is clean and the output register is free or draining
    always_comb begin
        q_pop_o = 1'b0;
        if (!rst && !q_empty_i && !hazard && !flush_i && (!iss_valid_o || accept))
            q_pop_o = 1'b1;
    end

    // Next state: flush wins, otherwise fill on pop and drain on accept
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (q_pop_o) state_d = S_FULL;
                S_FULL:  if (accept && !q_pop_o) state_d = S_EMPTY;
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
    end

    // Scoreboard next value: clear on writeback, set on accept (set wins), x0 stays 0
    always_comb begin
        sb_d = sb_q;
        if (wb_valid_i) sb_d[wb_rd_i] = 1'b0;
        if (accept && iss_has_rd_o && iss_rd_o != 5'd0) sb_d[iss_rd_o] = 1'b1;
        sb_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) sb_q <= '0;
        else     sb_q <= sb_d;
    end

    // Immediate expansion from the packed queue form
    always_comb begin
        case (h_ity)
            IMM_I:   head_imm = {{20{h_pimm[11]}}, h_pimm[11:0]};
            IMM_B:   head_imm = {{19{h_pimm[11]}}, h_pimm[11:0], 1'b0};
            IMM_U:   head_imm = {h_pimm[19:0], 12'b0};
            default: head_imm = {{11{h_pimm[19]}}, h_pimm[19:0], 1'b0};
        endcase
    end

    // Output register: loads only on pop so fields hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_uopcode_o  <= '0;
            iss_exu_type_o <= '0;
            iss_has_rd_o   <= 1'b0;
            iss_has_rs1_o  <= 1'b0;
            iss_has_rs2_o  <= 1'b0;
            iss_rd_o       <= '0;
            iss_rs1_o      <= '0;
            iss_rs2_o      <= '0;
            iss_imm_o      <= '0;
            iss_taken_o    <= 1'b0;
            iss_shadowed_o <= 1'b0;
        end else if (q_pop_o) begin
            iss_uopcode_o  <= h_uop;
            iss_exu_type_o <= h_exu;
            iss_has_rd_o   <= h_has_rd;
            iss_has_rs1_o  <= h_has_rs1;
            iss_has_rs2_o  <= h_has_rs2;
            iss_rd_o       <= h_rd;
            iss_rs1_o      <= h_rs1;
            iss_rs2_o      <= h_rs2;
            iss_imm_o      <= head_imm;
            iss_taken_o    <= h_taken;
            iss_shadowed_o <= h_shadowed;
        end
    end

`ifdef ISSUE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    logic [CNT_W-1:0] issued_cnt_q, stall_cnt_q;

    // Performance counters: accepted instructions and head-blocked cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (accept) issued_cnt_q <= issued_cnt_q + CNT_ONE;
            if (!q_empty_i && !flush_i && !q_pop_o) stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

    assign issued_cnt_o = issued_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`else
    assign issued_cnt_o = '0;
    assign stall_cnt_o  = '0;
`endif

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Consumer (read end) of the instruction queue that the decoder fills with queue_item_t entries.
- Pops entries and checks RAW/WAW hazards against a 32-entry register scoreboard.
- Decompresses packed_imm per imm_type and presents one instruction per cycle to the execute units over a valid/ready handshake.
- Sits between the instruction queue and the ALU/MUL/JMP/MEM execute units; writeback clears the scoreboard.

Parameters:
- NUM_EXU, 4, number of execute-unit ready lines, indexed by exut::exe_unit_type_t.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- q_item_i  input  50  queue_item_t at the queue head.
- q_empty_i  input  1  queue empty.
- q_pop_o  output  1  pop the queue head this cycle.
- flush_i  input  1  drop the held instruction (mispredict).
- wb_valid_i  input  1  writeback occurring.
- wb_rd_i  input  5  writeback destination.
- exu_ready_i  input  NUM_EXU  per-unit ready.
- iss_valid_o  output  1  held instruction valid.
- iss_uopcode_o  output  6  micro-opcode.
- iss_exu_type_o  output  2  target unit.
- iss_has_rd_o / iss_has_rs1_o / iss_has_rs2_o  output  1 each  operand usage.
- iss_rd_o / iss_rs1_o / iss_rs2_o  output  5 each  register indices.
- iss_imm_o  output  32  decompressed immediate.
- iss_taken_o / iss_shadowed_o  output  1 each  passed through from the queue item.
- sb_o  output  32  scoreboard pending bits (bit 0 is always 0).
- issued_cnt_o / stall_cnt_o  output  CNT_W each  perf counters (optional feature).

Behaviour:
- State machine on the output register: EMPTY (iss_valid_o=0) and FULL (iss_valid_o=1).
- Reset: EMPTY, sb=0, counters=0, every iss_* output 0, q_pop_o=0.
- accept = iss_valid_o & exu_ready_i[iss_exu_type_o].
- Output fields are stable while FULL and not accepted.
- Effective scoreboard: sb_eff = sb with bit wb_rd_i cleared when wb_valid_i (same-cycle writeback is visible).
- hazard =
  - (has_rs1 & rs1!=0 & sb_eff[rs1]) |
  - (has_rs2 & rs2!=0 & sb_eff[rs2]) |
  - (has_rd & rd!=0 & sb_eff[rd]) |
  - (iss_valid_o & iss_has_rd_o & iss_rd_o!=0 & has_rd/rs1/rs2 index equal to iss_rd_o). The held instruction is not yet in sb.
- Pop condition: q_pop_o = !q_empty_i & !hazard & !flush_i & (EMPTY | accept). Combinational; latency from queue head to iss_valid_o is one cycle.
- Transitions:
  - EMPTY → FULL on pop.
  - FULL → FULL on accept & pop (back-to-back, one issue per cycle).
  - FULL → EMPTY on accept & !pop.
  - FULL → EMPTY on flush_i, regardless of accept.
- flush_i takes priority over every transition and suppresses the pop.
- Accept during a flush cycle still counts as issued and still sets sb.
- Scoreboard set: on accept with iss_has_rd_o & iss_rd_o!=0, set sb[iss_rd_o].
- Scoreboard clear: on wb_valid_i, clear sb[wb_rd_i].
- Set and clear on the same index in the same cycle: set wins.
- sb[0] is never set.
- flush_i does not clear sb; already-issued producers still write back.
- Immediate decompression (registered with the entry), p = packed_imm:
  - i (covers I and S): sext(p[11:0]).
  - b: sext({p[11:0],1'b0}).
  - u: {p[19:0],12'b0}.
  - j: sext({p[19:0],1'b0}).
- Reset mid-operation: the held instruction is dropped, sb is cleared, and there is no pop in the reset cycle.

Optional Feature:
- Macro: ISSUE_PERF_EN.
- Defined:
  - issued_cnt_o increments on every accept.
  - stall_cnt_o increments each cycle with !q_empty_i & !flush_i & !q_pop_o.
  - Both counters wrap at 2^CNT_W and reset to 0.
- Undefined: no counter registers; both outputs are tied to 0.

Test Plan:
- Back-to-back independent: addi x1 then addi x2, all ready=1 → q_pop_o=1 both cycles; iss_valid_o=1 for 2 consecutive cycles; sb=0x6 after both accepts.
- RAW stall: add x3←x1,x2 with sb[1]=1 → q_pop_o=0, stall_cnt_o increments each cycle (ISSUE_PERF_EN); wb_valid_i=1, wb_rd_i=1 → pop in that same cycle, iss_valid_o=1 next cycle.
- Held-rd hazard: lw x5 held with exu_ready_i[mem]=0 and head add x6←x5,x0 → no pop until accept; sb[5]=1 after accept; add is still blocked until wb of x5.
- Backpressure plus flush: FULL with exu_ready_i=0 for 3 cycles → outputs unchanged; flush_i=1 → iss_valid_o=0 next cycle, no pop, sb unchanged.
- Immediate decode:
  - imm_type=b, p=0x00FFF → iss_imm_o=0xFFFFFFFE.
  - u, p=0x12345 → 0x12345000.
  - j, p=0x80000 → 0xFFF00000.
  - i, p=0x007FF → 0x000007FF.
- x0 and collision: accept with rd=x0 → sb unchanged; accept of rd=x7 with wb_rd_i=7 in the same cycle → sb[7]=1.
